// File: rtl/seq_recognizer_ctrl_if.sv
// Config, control and recognition signals between host/input bus and seq_recognizer_ctrl.
// master drives config, control and x; slave is the recognizer.
interface seq_recognizer_ctrl_if #(
    parameter int N  = 2,
    parameter int CW = 8
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic [N-1:0]  cfg_sym;
    logic          cfg_last;
    logic          start;
    logic          stop;
    logic [N-1:0]  x;
    logic          x_valid;
    logic          z;
    logic [CW-1:0] match_count;
    logic          busy;
    logic          err;

    modport master (
        output cfg_valid, cfg_sym, cfg_last, start, stop, x, x_valid,
        input  cfg_ready, z, match_count, busy, err
    );

    modport slave (
        input  cfg_valid, cfg_sym, cfg_last, start, stop, x, x_valid,
        output cfg_ready, z, match_count, busy, err
    );
endinterface

// File: rtl/seq_recognizer_ctrl.sv
// Programmable sequence recognizer: loads a 1..K_MAX symbol pattern, then pulses z one
// cycle after each complete match on the qualified x stream and counts matches (saturating).
module seq_recognizer_sym_cmp #(
    parameter int N = 2
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] sym,
    output logic         hit
);
    assign hit = (x == sym);
endmodule

module seq_recognizer_ctrl #(
    parameter int N     = 2,
    parameter int K_MAX = 4,
    parameter int CW    = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    seq_recognizer_ctrl_if.slave  bus
);
    localparam int PW = (K_MAX > 1) ? $clog2(K_MAX) : 1;
    localparam int LW = $clog2(K_MAX + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(K_MAX - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [K_MAX-1:0][N-1:0] pat_q, pat_d;
    logic [LW-1:0]           len_q, len_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [PW-1:0]           step_q, step_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    z_q, z_d;
    logic                    err_q, err_d;

    logic [K_MAX-1:0]        hit;
    logic                    cfg_hs;
    logic                    sym_hit;
    logic                    at_end;

    // one comparator per pattern slot; the FSM picks the slot for the current step
    for (genvar g = 0; g < K_MAX; g++) begin : g_cmp
        seq_recognizer_sym_cmp #(.N(N)) u_cmp (
            .x   (bus.x),
            .sym (pat_q[g]),
            .hit (hit[g])
        );
    end

    assign cfg_hs  = bus.cfg_valid && (state_q == S_IDLE);
    assign sym_hit = hit[step_q];
    assign at_end  = ((LW'(step_q) + LW'(1)) == len_q);

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ptr_d   = ptr_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        z_d     = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_hs) begin
                    pat_d[ptr_q] = bus.cfg_sym;
                    // first beat of a new load invalidates the stored pattern
                    if (ptr_q == '0) len_d = '0;
                    if (bus.cfg_last || (ptr_q == PTR_LAST)) begin
                        len_d = LW'(ptr_q) + LW'(1);
                        ptr_d = '0;
                    end else begin
                        ptr_d = ptr_q + PW'(1);
                    end
                end else if (bus.start) begin
                    if (len_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        step_d  = '0;
                        cnt_d   = '0;
                        ptr_d   = '0;
                    end
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                    step_d  = '0;
                end else if (bus.x_valid) begin
                    if (sym_hit && at_end) begin
                        z_d    = 1'b1;
                        step_d = '0;
                        if (!(&cnt_q)) cnt_d = cnt_q + CW'(1);
                    end else if (sym_hit) begin
                        step_d = step_q + PW'(1);
                    end else begin
                        // no back-tracking: only the first symbol may restart a match
                        step_d = hit[0] ? PW'(1) : '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ptr_q   <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            z_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            err_q   <= err_d;
        end
    end

    assign bus.cfg_ready   = (state_q == S_IDLE);
    assign bus.busy        = (state_q == S_RUN);
    assign bus.z           = z_q;
    assign bus.err         = err_q;
    assign bus.match_count = cnt_q;
endmodule

// File: tb/tb_seq_recognizer_ctrl.sv
// Bench for seq_recognizer_ctrl: directed scenarios plus a random run against a
// queue-based model of pattern loading and prefix matching.
module tb_seq_recognizer_ctrl;
    localparam int N     = 2;
    localparam int K_MAX = 4;
    localparam int CW    = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    seq_recognizer_ctrl_if #(.N(N), .CW(CW)) sif ();

    seq_recognizer_ctrl #(.N(N), .K_MAX(K_MAX), .CW(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (sif)
    );

    int n_checks = 0;
    int n_errors = 0;

    // model: pattern as completed list, load buffer and matched prefix as queues
    bit           m_run;
    int           m_len;
    int           m_count;
    bit           m_z;
    bit           m_err;
    logic [N-1:0] m_pat [K_MAX];
    logic [N-1:0] m_load[$];
    logic [N-1:0] m_part[$];

    function void model_step(bit rst, bit cv, logic [N-1:0] sym, bit cl, bit st, bit sp,
                             logic [N-1:0] xx, bit xv);
        m_z   = 1'b0;
        m_err = 1'b0;
        if (rst) begin
            m_run = 1'b0; m_len = 0; m_count = 0;
            m_load.delete(); m_part.delete();
            return;
        end
        if (!m_run) begin
            if (cv) begin
                m_load.push_back(sym);
                if (m_load.size() == 1) m_len = 0;
                if (cl || m_load.size() == K_MAX) begin
                    foreach (m_load[i]) m_pat[i] = m_load[i];
                    m_len = m_load.size();
                    m_load.delete();
                end
            end else if (st) begin
                if (m_len == 0) m_err = 1'b1;
                else begin
                    m_run = 1'b1; m_count = 0;
                    m_part.delete(); m_load.delete();
                end
            end
        end else if (sp) begin
            m_run = 1'b0;
            m_part.delete();
        end else if (xv) begin
            if (xx == m_pat[m_part.size()]) m_part.push_back(xx);
            else begin
                m_part.delete();
                if (xx == m_pat[0]) m_part.push_back(xx);
            end
            if (m_part.size() == m_len) begin
                m_z = 1'b1;
                if (m_count < (1 << CW) - 1) m_count++;
                m_part.delete();
            end
        end
    endfunction

    task automatic tick(input bit rst, input bit cv, input logic [N-1:0] sym, input bit cl,
                        input bit st, input bit sp, input logic [N-1:0] xx, input bit xv);
        reset         = rst;
        sif.cfg_valid = cv;
        sif.cfg_sym   = sym;
        sif.cfg_last  = cl;
        sif.start     = st;
        sif.stop      = sp;
        sif.x         = xx;
        sif.x_valid   = xv;
        model_step(rst, cv, sym, cl, st, sp, xx, xv);
        @(posedge clock);
        #1;
    endtask

    task automatic idle();                      tick(0, 0, 2'd0, 0, 0, 0, 2'd0, 0); endtask
    task automatic rst_cyc();                   tick(1, 0, 2'd0, 0, 0, 0, 2'd0, 0); endtask
    task automatic load(input logic [N-1:0] s, input bit l); tick(0, 1, s, l, 0, 0, 2'd0, 0); endtask
    task automatic start_p();                   tick(0, 0, 2'd0, 0, 1, 0, 2'd0, 0); endtask
    task automatic xin(input logic [N-1:0] v, input bit vl); tick(0, 0, 2'd0, 0, 0, 0, v, vl); endtask

    task automatic test_reset();
        rst_cyc();
        rst_cyc();
        n_checks++; if (sif.z !== 1'b0) begin n_errors++; $display("FAIL reset_z got %b exp 0", sif.z); end
        n_checks++; if (sif.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", sif.busy); end
        n_checks++; if (sif.err !== 1'b0) begin n_errors++; $display("FAIL reset_err got %b exp 0", sif.err); end
        n_checks++; if (sif.match_count !== 8'd0) begin n_errors++; $display("FAIL reset_count got %0d exp 0", sif.match_count); end
        n_checks++; if (sif.cfg_ready !== 1'b1) begin n_errors++; $display("FAIL reset_cfg_ready got %b exp 1", sif.cfg_ready); end
    endtask

    task automatic test_basic();
        load(2'b11, 0); load(2'b01, 0); load(2'b10, 1);
        start_p();
        n_checks++; if (sif.busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy got %b exp 1", sif.busy); end
        n_checks++; if (sif.cfg_ready !== 1'b0) begin n_errors++; $display("FAIL basic_cfg_ready got %b exp 0", sif.cfg_ready); end
        xin(2'b11, 1);
        n_checks++; if (sif.z !== 1'b0) begin n_errors++; $display("FAIL basic_z1 got %b exp 0", sif.z); end
        xin(2'b01, 1);
        n_checks++; if (sif.z !== 1'b0) begin n_errors++; $display("FAIL basic_z2 got %b exp 0", sif.z); end
        xin(2'b10, 1);
        n_checks++; if (sif.z !== 1'b1) begin n_errors++; $display("FAIL basic_z3 got %b exp 1", sif.z); end
        n_checks++; if (sif.match_count !== 8'd1) begin n_errors++; $display("FAIL basic_count got %0d exp 1", sif.match_count); end
        idle();
        n_checks++; if (sif.z !== 1'b0) begin n_errors++; $display("FAIL basic_z_after got %b exp 0", sif.z); end
    endtask

    task automatic test_restart();
        logic [N-1:0] s1 [4] = '{2'b11, 2'b11, 2'b01, 2'b10};
        logic [N-1:0] s2 [5] = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b10};
        int zc = 0;
        foreach (s1[i]) begin xin(s1[i], 1); zc += int'(sif.z); end
        n_checks++; if (zc !== 1 || sif.z !== 1'b1) begin n_errors++; $display("FAIL restart_a pulses %0d last_z %b exp 1 1", zc, sif.z); end
        zc = 0;
        foreach (s2[i]) begin xin(s2[i], 1); zc += int'(sif.z); end
        n_checks++; if (zc !== 1 || sif.z !== 1'b1) begin n_errors++; $display("FAIL restart_b pulses %0d last_z %b exp 1 1", zc, sif.z); end
        n_checks++; if (sif.match_count !== 8'd3) begin n_errors++; $display("FAIL restart_count got %0d exp 3", sif.match_count); end
        tick(0, 0, 2'd0, 0, 0, 1, 2'd0, 0);
        n_checks++; if (sif.busy !== 1'b0) begin n_errors++; $display("FAIL stop_busy got %b exp 0", sif.busy); end
        n_checks++; if (sif.match_count !== 8'd3) begin n_errors++; $display("FAIL stop_count_kept got %0d exp 3", sif.match_count); end
    endtask

    task automatic test_err_overflow();
        rst_cyc();
        start_p();
        n_checks++; if (sif.err !== 1'b1 || sif.busy !== 1'b0) begin n_errors++; $display("FAIL err_nopat err %b busy %b exp 1 0", sif.err, sif.busy); end
        idle();
        n_checks++; if (sif.err !== 1'b0) begin n_errors++; $display("FAIL err_one_cycle got %b exp 0", sif.err); end
        load(2'd0, 0); load(2'd1, 0); load(2'd2, 0); load(2'd3, 0); load(2'd1, 0);
        start_p();
        n_checks++; if (sif.err !== 1'b1 || sif.busy !== 1'b0) begin n_errors++; $display("FAIL fifth_beat_new_load err %b busy %b exp 1 0", sif.err, sif.busy); end
        rst_cyc();
        load(2'd0, 0); load(2'd1, 0); load(2'd2, 0); load(2'd3, 0);
        start_p();
        n_checks++; if (sif.busy !== 1'b1 || sif.err !== 1'b0) begin n_errors++; $display("FAIL forced_last busy %b err %b exp 1 0", sif.busy, sif.err); end
        xin(2'd0, 1); xin(2'd1, 1); xin(2'd2, 1); xin(2'd3, 1);
        n_checks++; if (sif.z !== 1'b1) begin n_errors++; $display("FAIL len4_match got %b exp 1", sif.z); end
    endtask

    task automatic test_gaps_stop();
        rst_cyc();
        load(2'b11, 0); load(2'b01, 0); load(2'b10, 1);
        start_p();
        xin(2'b11, 1); xin(2'b10, 0); xin(2'b01, 1); xin(2'b00, 0);
        n_checks++; if (sif.z !== 1'b0) begin n_errors++; $display("FAIL gap_no_early_z got %b exp 0", sif.z); end
        xin(2'b10, 1);
        n_checks++; if (sif.z !== 1'b1) begin n_errors++; $display("FAIL gap_match got %b exp 1", sif.z); end
        xin(2'b11, 1); xin(2'b01, 1);
        tick(0, 0, 2'd0, 0, 0, 1, 2'b10, 1);
        n_checks++; if (sif.z !== 1'b0 || sif.busy !== 1'b0) begin n_errors++; $display("FAIL stop_wins z %b busy %b exp 0 0", sif.z, sif.busy); end
        idle();
        n_checks++; if (sif.z !== 1'b0 || sif.match_count !== 8'd1) begin n_errors++; $display("FAIL stop_after z %b count %0d exp 0 1", sif.z, sif.match_count); end
    endtask

    task automatic test_saturate();
        int zc = 0;
        rst_cyc();
        load(2'b10, 1);
        start_p();
        for (int i = 0; i < 300; i++) begin xin(2'b10, 1); zc += int'(sif.z); end
        n_checks++; if (zc !== 300) begin n_errors++; $display("FAIL sat_pulses got %0d exp 300", zc); end
        n_checks++; if (sif.match_count !== 8'd255) begin n_errors++; $display("FAIL sat_count got %0d exp 255", sif.match_count); end
        tick(1, 0, 2'd0, 0, 0, 0, 2'b10, 1);
        n_checks++; if (sif.busy !== 1'b0 || sif.match_count !== 8'd0 || sif.z !== 1'b0) begin
            n_errors++; $display("FAIL midrun_reset busy %b count %0d z %b exp 0 0 0", sif.busy, sif.match_count, sif.z); end
        start_p();
        n_checks++; if (sif.err !== 1'b1) begin n_errors++; $display("FAIL reset_discards_pattern err %b exp 1", sif.err); end
    endtask

    task automatic test_random();
        bit rst, cv, cl, st, sp, xv;
        logic [N-1:0] sym, xx;
        rst_cyc();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            cv  = m_run ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 4);
            sym = N'($urandom);
            cl  = ($urandom_range(0, 9) < 3);
            st  = m_run ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 9) == 0);
            sp  = m_run ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 99) == 0);
            xv  = ($urandom_range(0, 9) < 7);
            if (m_run && m_len > 0 && $urandom_range(0, 1) == 1) xx = m_pat[m_part.size()];
            else xx = N'($urandom);
            tick(rst, cv, sym, cl, st, sp, xx, xv);
            n_checks++; if (sif.z !== m_z) begin n_errors++; $display("FAIL rnd_z cyc %0d got %b exp %b", c, sif.z, m_z); end
            n_checks++; if (sif.err !== m_err) begin n_errors++; $display("FAIL rnd_err cyc %0d got %b exp %b", c, sif.err, m_err); end
            n_checks++; if (sif.busy !== m_run) begin n_errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", c, sif.busy, m_run); end
            n_checks++; if (sif.cfg_ready !== !m_run) begin n_errors++; $display("FAIL rnd_cfg_ready cyc %0d got %b exp %b", c, sif.cfg_ready, !m_run); end
            n_checks++; if (sif.match_count !== CW'(m_count)) begin n_errors++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", c, sif.match_count, m_count); end
            n_checks++; if (sif.z && sif.err) begin n_errors++; $display("FAIL rnd_z_err_excl cyc %0d got 1 1 exp not both", c); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_restart();
        test_err_overflow();
        test_gaps_stop();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
